// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants for the AXI read arbiter.
// Holds the requester IDs, the AXI size encodings and the width of the
// per-ID outstanding-read counters.
package axi_rd_arbiter_pkg;
  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [2:0] AXSIZE_1B = 3'd0;
  localparam logic [2:0] AXSIZE_2B = 3'd1;
  localparam logic [2:0] AXSIZE_4B = 3'd2;

  // The counter is 3 bits wide, so MAX_OUT can be at most 7.
  localparam int CNT_W = 3;
endpackage

// File: rtl/axi_rd_arbiter_rd_out_cnt.sv
// rd_out_cnt: saturating up/down counter of the reads outstanding for one ID.
// Ports: clk/reset; i_inc (AR handshake), i_dec (R handshake);
//        o_count (current count), o_full (count == MAX_OUT).
module rd_out_cnt
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] r_count;

  // An increment and a decrement in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   if (r_count != MAX_CNT) r_count <= r_count + 1'b1;
        2'b01:   if (r_count != '0)      r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == MAX_CNT);
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI AR/R channel pair between the instruction
// fetch (ID 0) and the data load (ID 1) requesters.
// Ports: inst_*/data_* request and response groups; wr_pend/wr_pend_addr
//        from the write path (read-after-write hazard); AR master channel
//        (arid/araddr/arsize/arvalid/arready); R channel
//        (rid/rdata/rvalid/rready); sticky rid_err.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [2:0]  inst_size,
  output logic        inst_ready,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  output logic        data_ready,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  input  logic        wr_pend,
  input  logic [31:0] wr_pend_addr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic        rid_err
);
  localparam int ST_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STARVE_LIM);

  logic             r_arvalid, r_rready, r_rid_err;
  logic [3:0]       r_arid;
  logic [31:0]      r_araddr;
  logic [2:0]       r_arsize;
  logic [ST_W-1:0]  r_starve;

  logic [CNT_W-1:0] w_cnt_i, w_cnt_d;
  logic             w_full_i, w_full_d;
  logic             w_slot_free, w_ar_hs, w_r_hs, w_hazard;
  logic             w_elig_i, w_elig_d, w_force_i, w_gnt_i, w_gnt_d;
  logic             w_rv_i, w_rv_d;
  logic             w_unused;

  // Only the word address takes part in the hazard compare.
  assign w_unused = &{1'b0, wr_pend_addr[1:0]};

  assign w_slot_free = !r_arvalid || arready;
  assign w_ar_hs     = r_arvalid && arready;
  assign w_r_hs      = rvalid && r_rready;
  assign w_hazard    = wr_pend && (wr_pend_addr[31:2] == data_addr[31:2]);

  assign w_elig_i  = inst_req && !w_full_i;
  assign w_elig_d  = data_req && !w_full_d && !w_hazard;
  // Inst is forced through once data has won STARVE_LIM times in a row.
  assign w_force_i = w_elig_i && (r_starve == ST_MAX);
  assign w_gnt_d   = !reset && w_slot_free && w_elig_d && !w_force_i;
  assign w_gnt_i   = !reset && w_slot_free && w_elig_i && !w_gnt_d;

  // A beat is delivered only to an ID that actually has reads in flight.
  assign w_rv_i = w_r_hs && (rid == ID_INST) && (w_cnt_i != '0);
  assign w_rv_d = w_r_hs && (rid == ID_DATA) && (w_cnt_d != '0);

  rd_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt_i (
    .clk(clk), .reset(reset),
    .i_inc(w_ar_hs && (r_arid == ID_INST)), .i_dec(w_rv_i),
    .o_count(w_cnt_i), .o_full(w_full_i)
  );

  rd_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt_d (
    .clk(clk), .reset(reset),
    .i_inc(w_ar_hs && (r_arid == ID_DATA)), .i_dec(w_rv_d),
    .o_count(w_cnt_d), .o_full(w_full_d)
  );

  // AR slot: a grant may reload it in the same cycle the previous AR leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arsize  <= '0;
    end else if (w_gnt_d) begin
      r_arvalid <= 1'b1;
      r_arid    <= ID_DATA;
      r_araddr  <= data_addr;
      r_arsize  <= data_size;
    end else if (w_gnt_i) begin
      r_arvalid <= 1'b1;
      r_arid    <= ID_INST;
      r_araddr  <= inst_addr;
      r_arsize  <= inst_size;
    end else if (w_ar_hs) begin
      r_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve  <= '0;
      r_rready  <= 1'b0;
      r_rid_err <= 1'b0;
    end else begin
      r_rready <= 1'b1;
      if (w_gnt_i)
        r_starve <= '0;
      else if (w_gnt_d && w_elig_i && (r_starve != ST_MAX))
        r_starve <= r_starve + 1'b1;
      if (w_r_hs && !w_rv_i && !w_rv_d)
        r_rid_err <= 1'b1;
    end
  end

  assign inst_ready  = w_gnt_i;
  assign data_ready  = w_gnt_d;
  assign inst_rvalid = w_rv_i;
  assign data_rvalid = w_rv_d;
  assign inst_rdata  = rdata;
  assign data_rdata  = rdata;
  assign arvalid     = r_arvalid;
  assign arid        = r_arid;
  assign araddr      = r_araddr;
  assign arsize      = r_arsize;
  assign rready      = r_rready;
  assign rid_err     = r_rid_err;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        inst_req = 0, data_req = 0, wr_pend = 0, arready = 1, rvalid = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, wr_pend_addr = 0, rdata = 0;
  logic [2:0]  inst_size = 0, data_size = 0;
  logic [3:0]  rid = 0;
  logic        inst_ready, inst_rvalid, data_ready, data_rvalid, arvalid, rready, rid_err;
  logic [31:0] inst_rdata, data_rdata, araddr;
  logic [3:0]  arid;
  logic [2:0]  arsize;
  int n_cmp = 0, n_bad = 0;

  axi_rd_arbiter #(.MAX_OUT(2), .STARVE_LIM(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_ready(inst_ready), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_ready(data_ready), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .wr_pend(wr_pend), .wr_pend_addr(wr_pend_addr),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .rid_err(rid_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; wr_pend = 0; rvalid = 0; rid = 0; rdata = 0;
    inst_addr = 0; data_addr = 0; wr_pend_addr = 0; inst_size = 0; data_size = 0;
    arready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; step(); step(); reset = 0; step();
  endtask

  // One-cycle inst request pulse, then wait until the AR has been counted.
  task automatic issue_inst(input logic [31:0] a);
    inst_req = 1; inst_addr = a; inst_size = 3'd2;
    step(); inst_req = 0;
    step(); step();
  endtask

  task automatic test_reset();
    reset = 1; inst_req = 1; data_req = 1; rvalid = 1; rid = 0;
    @(negedge clk);
    n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid got %b want 0", arvalid); end
    n_cmp++; if ({arid, araddr, arsize} !== 39'd0) begin n_bad++; $display("FAIL rst_ar_payload got %h want 0", {arid, araddr, arsize}); end
    n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL rst_rready got %b want 0", rready); end
    n_cmp++; if ({inst_ready, data_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_ready got %b want 00", {inst_ready, data_ready}); end
    n_cmp++; if ({inst_rvalid, data_rvalid, rid_err} !== 3'b000) begin n_bad++; $display("FAIL rst_rvalid_err got %b want 000", {inst_rvalid, data_rvalid, rid_err}); end
    idle_inputs(); step(); reset = 0; step();
    @(negedge clk);
    n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL rst_rready_after got %b want 1", rready); end
  endtask

  task automatic test_single_inst();
    do_reset();
    inst_req = 1; inst_addr = 32'h1FC0_0000; inst_size = 3'd2;
    @(negedge clk);
    n_cmp++; if ({inst_ready, data_ready} !== 2'b10) begin n_bad++; $display("FAIL single_accept got %b want 10", {inst_ready, data_ready}); end
    step(); inst_req = 0;
    @(negedge clk);
    n_cmp++; if (arvalid !== 1'b1 || arid !== 4'd0) begin n_bad++; $display("FAIL single_ar got v=%b id=%0d want v=1 id=0", arvalid, arid); end
    n_cmp++; if (araddr !== 32'h1FC0_0000 || arsize !== 3'd2) begin n_bad++; $display("FAIL single_payload got %h/%0d want 1fc00000/2", araddr, arsize); end
    step(); rvalid = 1; rid = 0; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL single_ar_drop got %b want 0", arvalid); end
    n_cmp++; if (inst_rvalid !== 1'b1 || data_rvalid !== 1'b0) begin n_bad++; $display("FAIL single_rvalid got i=%b d=%b want i=1 d=0", inst_rvalid, data_rvalid); end
    n_cmp++; if (inst_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_rdata got %h want deadbeef", inst_rdata); end
    step(); rvalid = 0;
    @(negedge clk);
    n_cmp++; if (dut.w_cnt_i !== 3'd0 || rid_err !== 1'b0) begin n_bad++; $display("FAIL single_cnt got cnt=%0d err=%b want 0/0", dut.w_cnt_i, rid_err); end
  endtask

  task automatic test_starve();
    byte exp_g [8];
    logic hs;
    logic [3:0] hid;
    byte g;
    exp_g = '{"D", "D", "D", "I", "D", "D", "D", "I"};
    do_reset();
    inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = data_ready ? "D" : (inst_ready ? "I" : "-");
      n_cmp++; if (g != exp_g[i] || (inst_ready && data_ready)) begin n_bad++; $display("FAIL starve_grant%0d got %c want %c", i, g, exp_g[i]); end
      hs = arvalid && arready; hid = arid;
      step();
      // Return one beat for each AR so neither counter fills up.
      rvalid = hs; rid = hid; rdata = i;
    end
    do_reset();
  endtask

  task automatic test_full();
    do_reset();
    issue_inst(32'h100);
    issue_inst(32'h104);
    inst_req = 1; inst_addr = 32'h108;
    @(negedge clk);
    n_cmp++; if (inst_ready !== 1'b0 || dut.w_cnt_i !== 3'd2) begin n_bad++; $display("FAIL full_block got rdy=%b cnt=%0d want 0/2", inst_ready, dut.w_cnt_i); end
    step(); rvalid = 1; rid = 0; rdata = 32'h11;
    @(negedge clk);
    n_cmp++; if (inst_ready !== 1'b0 || inst_rvalid !== 1'b1) begin n_bad++; $display("FAIL full_rbeat got rdy=%b rv=%b want 0/1", inst_ready, inst_rvalid); end
    step(); rvalid = 0;
    @(negedge clk);
    n_cmp++; if (inst_ready !== 1'b1) begin n_bad++; $display("FAIL full_release got %b want 1", inst_ready); end
    step(); inst_req = 0;
  endtask

  task automatic test_hazard();
    do_reset();
    wr_pend = 1; wr_pend_addr = 32'h8000_0104;
    data_req = 1; data_addr = 32'h8000_0106; data_size = 3'd1;
    inst_req = 1; inst_addr = 32'h40;
    @(negedge clk);
    n_cmp++; if ({inst_ready, data_ready} !== 2'b10) begin n_bad++; $display("FAIL haz_block got %b want 10", {inst_ready, data_ready}); end
    step(); inst_req = 0;
    @(negedge clk);
    n_cmp++; if (data_ready !== 1'b0 || arvalid !== 1'b1 || arid !== 4'd0) begin n_bad++; $display("FAIL haz_hold got rdy=%b v=%b id=%0d want 0/1/0", data_ready, arvalid, arid); end
    step(); wr_pend = 0;
    @(negedge clk);
    n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL haz_release got %b want 1", data_ready); end
    step(); data_req = 0;
    @(negedge clk);
    n_cmp++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h8000_0106 || arsize !== 3'd1) begin n_bad++; $display("FAIL haz_ar got v=%b id=%0d a=%h s=%0d want 1/1/80000106/1", arvalid, arid, araddr, arsize); end
    // Same pending write, different word: no stall.
    step(); wr_pend = 1; data_req = 1; data_addr = 32'h8000_0108;
    @(negedge clk);
    n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL haz_other_word got %b want 1", data_ready); end
    step(); data_req = 0; wr_pend = 0;
  endtask

  task automatic test_bad_rid();
    do_reset();
    rvalid = 1; rid = 4'd3; rdata = 32'h55;
    @(negedge clk);
    n_cmp++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin n_bad++; $display("FAIL badrid_rvalid got %b want 00", {inst_rvalid, data_rvalid}); end
    step(); rvalid = 0;
    @(negedge clk);
    n_cmp++; if (rid_err !== 1'b1) begin n_bad++; $display("FAIL badrid_err got %b want 1", rid_err); end
    step(); step(); step();
    @(negedge clk);
    n_cmp++; if (rid_err !== 1'b1) begin n_bad++; $display("FAIL badrid_sticky got %b want 1", rid_err); end
    do_reset();
    @(negedge clk);
    n_cmp++; if (rid_err !== 1'b0) begin n_bad++; $display("FAIL badrid_clear got %b want 0", rid_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_inst(32'h100);
    issue_inst(32'h104);
    arready = 0; data_req = 1; data_addr = 32'h200; data_size = 3'd2;
    @(negedge clk);
    n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL mid_grant got %b want 1", data_ready); end
    step(); data_req = 0; step();
    @(negedge clk);
    n_cmp++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h200) begin n_bad++; $display("FAIL mid_hold got v=%b id=%0d a=%h want 1/1/200", arvalid, arid, araddr); end
    n_cmp++; if (dut.w_cnt_i !== 3'd2) begin n_bad++; $display("FAIL mid_cnt got %0d want 2", dut.w_cnt_i); end
    step(); #2; reset = 1; #1;
    n_cmp++; if (arvalid !== 1'b0 || dut.w_cnt_i !== 3'd0 || dut.w_cnt_d !== 3'd0) begin n_bad++; $display("FAIL mid_reset got v=%b ci=%0d cd=%0d want 0/0/0", arvalid, dut.w_cnt_i, dut.w_cnt_d); end
    step(); arready = 1; reset = 0; step();
    rvalid = 1; rid = 0;
    @(negedge clk);
    n_cmp++; if (inst_rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_late_rvalid got %b want 0", inst_rvalid); end
    step(); rvalid = 0;
    @(negedge clk);
    n_cmp++; if (rid_err !== 1'b1) begin n_bad++; $display("FAIL mid_late_err got %b want 1", rid_err); end
  endtask

  initial begin
    test_reset();
    test_single_inst();
    test_starve();
    test_full();
    test_hazard();
    test_bad_rid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
